// File: rtl/fetch_queue_if.sv
// Decode-side handshake bundle for fetch_queue.
// master = fetch stage, slave = decode.
interface fetch_queue_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC, ROM read issue, tagged word FIFO, redirect.
// Optional FETCH_STALL_COUNT_EN adds a saturating decode-starvation counter.
module fetch_queue #(
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 16,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int             PTR_W    = $clog2(DEPTH),
    localparam int             CNT_W    = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_read_enable,
    input  logic [DATA_W-1:0] rom_data,
    fetch_queue_if.master     dq,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_STALL_COUNT_EN
    output logic [15:0]       stall_count,
`endif
    output logic [CNT_W-1:0]  fifo_count
);
    localparam int CW1 = CNT_W + 1;

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_nxt;
    logic [CNT_W-1:0]  count;
    logic [CW1-1:0]    credit;
    logic              issue;
    logic              push;
    logic              pop;

    // Credit counts the in-flight read so a push can never overflow.
    assign credit = {1'b0, count} + CW1'(inflight);
    assign issue  = !reset && !redirect && (credit < CW1'(DEPTH));
    assign push   = inflight;
    assign pop    = dq.instr_valid && dq.instr_ready;
    assign rd_nxt = rd_ptr + 1'b1;

    assign rom_address     = pc;
    assign rom_read_enable = issue;
    assign fifo_count      = count;
    assign dq.instr_valid  = (count != '0);

    always_ff @(posedge clk) begin
        if (!reset && !redirect && push) begin
            mem_data[wr_ptr] <= rom_data;
            mem_pc[wr_ptr]   <= inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            dq.instr    <= '0;
            dq.instr_pc <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) begin
                pc <= pc + 1'b1;
            end
            inflight    <= issue;
            inflight_pc <= pc;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            unique case (1'b1)
                (push && !pop): count <= count + 1'b1;
                (pop && !push): count <= count - 1'b1;
                default:        count <= count;
            endcase
            // Head registers track what the FIFO head will be after this edge.
            if (pop) begin
                if (count > CNT_W'(1)) begin
                    dq.instr    <= mem_data[rd_nxt];
                    dq.instr_pc <= mem_pc[rd_nxt];
                end else if (push) begin
                    dq.instr    <= rom_data;
                    dq.instr_pc <= inflight_pc;
                end
            end else if (count == '0 && push) begin
                dq.instr    <= rom_data;
                dq.instr_pc <= inflight_pc;
            end
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (dq.instr_ready && !dq.instr_valid
                     && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue with a one-cycle-latency ROM model
// returning {8'hA5, address}.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rom_address;
    logic        rom_read_enable;
    logic [15:0] rom_data = '0;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [2:0]  fifo_count;
`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int tests = 0;
    int fails = 0;

    fetch_queue_if #(.ADDR_W(8), .DATA_W(16)) dq ();

    fetch_queue dut (
        .clk             (clk),
        .reset           (reset),
        .rom_address     (rom_address),
        .rom_read_enable (rom_read_enable),
        .rom_data        (rom_data),
        .dq              (dq.master),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
`ifdef FETCH_STALL_COUNT_EN
        .stall_count     (stall_count),
`endif
        .fifo_count      (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_read_enable) rom_data <= {8'hA5, rom_address};
    end

    typedef struct {
        logic        ready;
        logic        redir;
        logic [7:0]  rpc;
        logic        valid;
        logic [15:0] instr;
        logic [7:0]  pc;
        logic [2:0]  cnt;
        logic        ren;
        logic [7:0]  addr;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        dq.instr_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic collect(input string name, input logic [7:0] base,
                           input int n, input int budget);
        int got = 0;
        dq.instr_ready = 1'b1;
        for (int c = 0; c < budget && got < n; c++) begin
            #1;
            if (dq.instr_valid) begin
                chk({name, "_word"}, {dq.instr_pc, dq.instr},
                    {base + 8'(got), 8'hA5, base + 8'(got)});
                got++;
            end
            @(posedge clk);
            #0;
        end
        chk({name, "_count"}, 64'(got), 64'(n));
    endtask

    initial begin
        vecs[0]  = '{1, 0, 8'h00, 0, 16'h0000, 8'h00, 3'd0, 1, 8'h00};
        vecs[1]  = '{1, 0, 8'h00, 0, 16'h0000, 8'h00, 3'd0, 1, 8'h01};
        vecs[2]  = '{1, 0, 8'h00, 1, 16'hA500, 8'h00, 3'd1, 1, 8'h02};
        vecs[3]  = '{1, 0, 8'h00, 1, 16'hA501, 8'h01, 3'd1, 1, 8'h03};
        vecs[4]  = '{1, 0, 8'h00, 1, 16'hA502, 8'h02, 3'd1, 1, 8'h04};
        vecs[5]  = '{1, 0, 8'h00, 1, 16'hA503, 8'h03, 3'd1, 1, 8'h05};
        vecs[6]  = '{1, 1, 8'hFE, 1, 16'hA504, 8'h04, 3'd1, 0, 8'h06};
        vecs[7]  = '{1, 0, 8'h00, 0, 16'hA504, 8'h04, 3'd0, 1, 8'hFE};
        vecs[8]  = '{1, 0, 8'h00, 0, 16'hA504, 8'h04, 3'd0, 1, 8'hFF};
        vecs[9]  = '{1, 0, 8'h00, 1, 16'hA5FE, 8'hFE, 3'd1, 1, 8'h00};
        vecs[10] = '{1, 0, 8'h00, 1, 16'hA5FF, 8'hFF, 3'd1, 1, 8'h01};
        vecs[11] = '{1, 0, 8'h00, 1, 16'hA500, 8'h00, 3'd1, 1, 8'h02};
        vecs[12] = '{1, 0, 8'h00, 1, 16'hA501, 8'h01, 3'd1, 1, 8'h03};

        // Read strobe must stay low while reset is held.
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        dq.instr_ready = 1'b1;
        next_cycle();
        #1 chk("reset_ren", 64'(rom_read_enable), 64'(0));

        // Streaming, redirect to FE and PC wrap.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            dq.instr_ready = vecs[i].ready;
            redirect = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            #1;
            chk($sformatf("vec%0d", i),
                {27'd0, dq.instr_valid, dq.instr, dq.instr_pc,
                 fifo_count, rom_read_enable, rom_address},
                {27'd0, vecs[i].valid, vecs[i].instr, vecs[i].pc,
                 vecs[i].cnt, vecs[i].ren, vecs[i].addr});
            next_cycle();
        end
        redirect = 1'b0;

        // Backpressure fills FIFO, then drains in order.
        do_reset();
        repeat (10) next_cycle();
        #1;
        chk("full_count", 64'(fifo_count), 64'(4));
        chk("full_ren", 64'(rom_read_enable), 64'(0));
        chk("full_head", {dq.instr_valid, dq.instr_pc, dq.instr},
            {1'b1, 8'h00, 16'hA500});
        collect("drain", 8'h00, 8, 40);

        // Redirect with 3 queued and one in flight.
        do_reset();
        repeat (4) next_cycle();
        redirect = 1'b1;
        redirect_pc = 8'h40;
        #1;
        chk("redir_pre_count", 64'(fifo_count), 64'(3));
        chk("redir_ren", 64'(rom_read_enable), 64'(0));
        next_cycle();
        redirect = 1'b0;
        #1;
        chk("redir_post", {dq.instr_valid, fifo_count, rom_read_enable,
                           rom_address}, {1'b0, 3'd0, 1'b1, 8'h40});
        collect("redir", 8'h40, 3, 20);

        // Reset mid-operation drops queued and in-flight data.
        dq.instr_ready = 1'b0;
        do_reset();
        repeat (3) next_cycle();
        #1 chk("mid_count", 64'(fifo_count), 64'(2));
        do_reset();
        #1;
        chk("mid_rst0", {dq.instr_valid, fifo_count, rom_address},
            {1'b0, 3'd0, 8'h00});
        next_cycle();
        #1;
        chk("mid_rst1", {dq.instr_valid, fifo_count}, {1'b0, 3'd0});
        next_cycle();
        #1;
        chk("mid_rst2", {dq.instr_valid, dq.instr_pc, dq.instr},
            {1'b1, 8'h00, 16'hA500});

`ifdef FETCH_STALL_COUNT_EN
        begin
            int c = 0;
            do_reset();
            dq.instr_ready = 1'b1;
            #1 chk("stall_init", 64'(stall_count), 64'(0));
            while (!dq.instr_valid && c < 10) begin
                next_cycle();
                #1;
                c++;
            end
            chk("stall_first", 64'(stall_count), 64'(2));
            dq.instr_ready = 1'b0;
            repeat (3) next_cycle();
            #1 chk("stall_hold", 64'(stall_count), 64'(2));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the CPU's instruction register (IR) load.
- Owns the 8-bit program counter and drives the synchronous instruction ROM.
- Buffers fetched 16-bit instruction words, each tagged with its PC, in a small FIFO.
- Hands words to decode over a valid/ready handshake; supports redirect (jump/branch) with flush.

Parameters:
- ADDR_W, 8, ROM address and PC width.
- DATA_W, 16, instruction word width: opcode[15:12], dest[11:6], src[5:0].
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_address  output  ADDR_W  ROM read address; equals the current PC.
- rom_read_enable  output  1  ROM read strobe; data returns on rom_data one cycle later.
- rom_data  input  DATA_W  ROM read data.
- instr  output  DATA_W  head-of-FIFO instruction word.
- instr_pc  output  ADDR_W  PC of the head word.
- instr_valid  output  1  head entry is valid.
- instr_ready  input  1  consumer accepts head when instr_valid && instr_ready.
- redirect  input  1  flush the FIFO and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_W  new fetch address.
- fifo_count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values:
  - PC = RESET_PC; rom_read_enable = 0.
  - FIFO empty: fifo_count = 0, instr_valid = 0.
  - instr = 0, instr_pc = 0; in-flight flag = 0.
- Read issue: rom_read_enable = 1 in any non-reset cycle where (fifo_count + inflight) < DEPTH and redirect = 0.
  - rom_address = PC.
  - PC <= PC + 1 on issue; wraps from 2^ADDR_W - 1 to 0 with no flag.
- Response capture:
  - The in-flight flag is set in the cycle after an issue and holds that issue's PC.
  - When set, rom_data is pushed into the FIFO with the tagged PC.
  - The credit rule guarantees a push never overflows.
- Pop: instr_valid && instr_ready frees the head entry at the clock edge.
  - Push and pop in the same cycle leaves count unchanged, including at count = DEPTH (pop frees the slot for the concurrent push).
- Outputs instr and instr_pc are registered FIFO head values, stable while instr_valid=1 && instr_ready=0.
- Throughput: with instr_ready held high, one word per cycle in steady state. First word after reset or redirect is valid 2 cycles after the first issue.
- Redirect (highest priority):
  - In cycle T with redirect=1: FIFO cleared, any in-flight response discarded (not pushed), PC <= redirect_pc, rom_read_enable = 0.
  - A handshake occurring in cycle T still counts as accepted.
  - First fetch of redirect_pc issues at T+1; instr_valid at T+3 with instr_pc = redirect_pc.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: all state returns to reset values on the next edge; in-flight data is discarded.
- Empty: instr_valid = 0; instr and instr_pc hold their last values.
- Full: no issue until a pop.

Optional Feature:
- Macro FETCH_STALL_COUNT_EN.
- Defined:
  - Adds output port stall_count, 16 bits.
  - Increments (saturating at 16'hFFFF) each cycle where instr_ready=1 && instr_valid=0 && reset=0.
  - Cleared by reset only.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ROM model rom[a] = {8'hA5, a}. Reset, then instr_ready=1 -> first handshake on instr=16'hA500, instr_pc=0 two cycles after first issue; then one word per cycle: A501, A502, A503.
- instr_ready=0 for 10 cycles -> fifo_count reaches 4; rom_read_enable=0 with no further issue; instr=A500 held stable. Release -> words 0..7 in order, no loss or duplicate.
- Redirect at T with redirect_pc=8'h40 while 3 words are queued and one is in flight -> fifo_count=0 at T+1; next accepted instr_pc=8'h40 with instr=A540; none of the flushed PCs appear.
- Redirect to 8'hFE with instr_ready=1 -> instr_pc sequence FE, FF, 00, 01 (wrap); instr=A5FE, A5FF, A500, A501.
- Assert reset for 1 cycle while FIFO holds 2 entries with one in flight -> next cycle instr_valid=0, fifo_count=0, rom_address=RESET_PC; stale rom_data is not pushed.
- With FETCH_STALL_COUNT_EN defined: instr_ready=1 from reset release -> stall_count=2 when the first instr_valid rises; no increment while stalled by instr_ready=0.
